instruction_fetch_queue: RTL and testbench

INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

---
 rtl/instruction_fetch_queue.sv | 124 ++++++++++++
 tb/tb_instruction_fetch_queue.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches against a one-cycle memory
// and buffers returned instructions with their PCs, flushing on branch redirect.
module instruction_fetch_queue #(
    parameter int                WIDTH    = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(32'd4)
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Redirect,
    input  logic [ADDR_W-1:0]        Redirect_Addr,
    output logic                     Mem_Req,
    output logic [ADDR_W-1:0]        Mem_Addr,
    input  logic [WIDTH-1:0]         Mem_Data,
    output logic [WIDTH-1:0]         Instr,
    output logic [ADDR_W-1:0]        Instr_PC,
    output logic                     Instr_Valid,
    input  logic                     Instr_Ready,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  data_mem_r [DEPTH];
    logic [ADDR_W-1:0] pc_mem_r   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [ADDR_W-1:0] fpc_r;
    logic              inflight_r;
    logic [ADDR_W-1:0] inflight_pc_r;

    logic              head_valid_s;
    logic              pop_s;
    logic              push_s;
    logic              issue_s;
    logic [CNT_W:0]    occupancy_s;
    logic [WIDTH-1:0]  instr_s;
    logic [ADDR_W-1:0] instr_pc_s;

    // Credit check, handshake decode and head-of-queue presentation.
    always_comb begin
        head_valid_s = Reset & (count_r != '0);
        pop_s        = head_valid_s & Instr_Ready;
        push_s       = inflight_r;
        // Entries held plus the response already on its way must leave room for one more.
        occupancy_s  = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r}
                     - {{CNT_W{1'b0}}, pop_s};
        issue_s      = Reset & ~Redirect & (occupancy_s < DEPTH_C);
        if (head_valid_s) begin
            instr_s    = data_mem_r[rd_ptr_r];
            instr_pc_s = pc_mem_r[rd_ptr_r];
        end else begin
            instr_s    = '0;
            instr_pc_s = '0;
        end
    end

    assign Mem_Req     = issue_s;
    assign Mem_Addr    = fpc_r;
    assign Instr       = instr_s;
    assign Instr_PC    = instr_pc_s;
    assign Instr_Valid = head_valid_s;
    assign Count       = count_r;

    // Fetch PC, in-flight tracking, pointers and occupancy; Redirect outranks everything but reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            fpc_r         <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= '0;
            rd_ptr_r      <= '0;
            wr_ptr_r      <= '0;
            count_r       <= '0;
        end else if (Redirect) begin
            fpc_r         <= Redirect_Addr;
            inflight_r    <= 1'b0;
            inflight_pc_r <= inflight_pc_r;
            rd_ptr_r      <= '0;
            wr_ptr_r      <= '0;
            count_r       <= '0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                fpc_r         <= fpc_r + PC_STEP;
                inflight_pc_r <= fpc_r;
            end else begin
                fpc_r         <= fpc_r;
                inflight_pc_r <= inflight_pc_r;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage; a response arriving alongside reset or Redirect is dropped.
    always_ff @(posedge Clk) begin
        if (Reset && !Redirect && push_s) begin
            data_mem_r[wr_ptr_r] <= Mem_Data;
            pc_mem_r[wr_ptr_r]   <= inflight_pc_r;
        end else begin
            data_mem_r[wr_ptr_r] <= data_mem_r[wr_ptr_r];
            pc_mem_r[wr_ptr_r]   <= pc_mem_r[wr_ptr_r];
        end
    end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue using a one-cycle memory that
// returns Mem_Addr + 0x1000.
module tb_instruction_fetch_queue;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Redirect;
    logic [31:0] Redirect_Addr;
    logic        Mem_Req;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_Data = 32'h0;
    logic [31:0] Instr;
    logic [31:0] Instr_PC;
    logic        Instr_Valid;
    logic        Instr_Ready;
    logic [2:0]  Count;

    int total = 0;
    int bad   = 0;

    instruction_fetch_queue dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Redirect      (Redirect),
        .Redirect_Addr (Redirect_Addr),
        .Mem_Req       (Mem_Req),
        .Mem_Addr      (Mem_Addr),
        .Mem_Data      (Mem_Data),
        .Instr         (Instr),
        .Instr_PC      (Instr_PC),
        .Instr_Valid   (Instr_Valid),
        .Instr_Ready   (Instr_Ready),
        .Count         (Count)
    );

    always #5 Clk = ~Clk;

    // One-cycle memory: data for this cycle's address appears in the next cycle.
    always @(posedge Clk) Mem_Data <= Mem_Addr + 32'h1000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, then let inputs settle.
    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    initial begin
        Reset = 1'b0; Redirect = 1'b0; Redirect_Addr = 32'h0; Instr_Ready = 1'b1;
        step(); step();
        // Held in reset
        chk("rst_req",   {31'h0, Mem_Req}, 32'h0);
        chk("rst_valid", {31'h0, Instr_Valid}, 32'h0);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_pc",    Instr_PC, 32'h0);
        chk("rst_count", {29'h0, Count}, 32'h0);

        // Release with Instr_Ready=1: streaming fetch
        Reset = 1'b1; #1;
        chk("a_c0_req",   {31'h0, Mem_Req}, 32'h1);
        chk("a_c0_addr",  Mem_Addr, 32'h0);
        chk("a_c0_valid", {31'h0, Instr_Valid}, 32'h0);
        step();
        chk("a_c1_addr",  Mem_Addr, 32'h4);
        chk("a_c1_valid", {31'h0, Instr_Valid}, 32'h0);
        step();
        chk("a_c2_valid", {31'h0, Instr_Valid}, 32'h1);
        chk("a_c2_pc",    Instr_PC, 32'h0);
        chk("a_c2_instr", Instr, 32'h1000);
        chk("a_c2_addr",  Mem_Addr, 32'h8);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("a_str_valid", {31'h0, Instr_Valid}, 32'h1);
            chk("a_str_pc",    Instr_PC, 32'(4 * k));
            chk("a_str_instr", Instr, 32'h1000 + 32'(4 * k));
            chk("a_str_count", {29'h0, Count}, 32'h1);
        end

        // Mid-run reset, then release with Instr_Ready=0: queue fills to 4
        Reset = 1'b0; #1;
        chk("b_rst_req",   {31'h0, Mem_Req}, 32'h0);
        chk("b_rst_valid", {31'h0, Instr_Valid}, 32'h0);
        chk("b_rst_instr", Instr, 32'h0);
        step();
        Reset = 1'b1; Instr_Ready = 1'b0; #1;
        chk("b_c0_count", {29'h0, Count}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            chk("b_iss_req",  {31'h0, Mem_Req}, 32'h1);
            chk("b_iss_addr", Mem_Addr, 32'(4 * k));
            step();
        end
        chk("b_c4_req",   {31'h0, Mem_Req}, 32'h0);
        chk("b_c4_count", {29'h0, Count}, 32'h3);
        step();
        chk("b_c5_req",   {31'h0, Mem_Req}, 32'h0);
        chk("b_c5_count", {29'h0, Count}, 32'h4);
        chk("b_c5_pc",    Instr_PC, 32'h0);
        chk("b_c5_instr", Instr, 32'h1000);
        Instr_Ready = 1'b1; #1;
        chk("b_resume_req",  {31'h0, Mem_Req}, 32'h1);
        chk("b_resume_addr", Mem_Addr, 32'h10);
        step();
        chk("b_c6_count", {29'h0, Count}, 32'h3);
        chk("b_c6_pc",    Instr_PC, 32'h4);

        // Redirect to 0x40 with Count=3 and 0x10 in flight
        Redirect = 1'b1; Redirect_Addr = 32'h40; #1;
        chk("c_redir_req", {31'h0, Mem_Req}, 32'h0);
        step();
        Redirect = 1'b0; #1;
        chk("c_r1_count", {29'h0, Count}, 32'h0);
        chk("c_r1_valid", {31'h0, Instr_Valid}, 32'h0);
        chk("c_r1_addr",  Mem_Addr, 32'h40);
        step();
        chk("c_r2_count", {29'h0, Count}, 32'h0);
        chk("c_r2_valid", {31'h0, Instr_Valid}, 32'h0);
        step();
        chk("c_r3_valid", {31'h0, Instr_Valid}, 32'h1);
        chk("c_r3_pc",    Instr_PC, 32'h40);
        chk("c_r3_instr", Instr, 32'h1040);
        chk("c_r3_count", {29'h0, Count}, 32'h1);

        // Redirect near the top of the address space: fetch PC wraps
        Redirect = 1'b1; Redirect_Addr = 32'hFFFF_FFFC;
        step();
        Redirect = 1'b0; #1;
        chk("d_r1_addr", Mem_Addr, 32'hFFFF_FFFC);
        step();
        chk("d_r2_addr", Mem_Addr, 32'h0);
        step();
        chk("d_r3_pc",    Instr_PC, 32'hFFFF_FFFC);
        chk("d_r3_instr", Instr, 32'h0000_0FFC);
        step();
        chk("d_r4_pc",    Instr_PC, 32'h0);
        chk("d_r4_instr", Instr, 32'h1000);
        step();
        chk("d_r5_pc",    Instr_PC, 32'h4);

        // Build Count=3 with one fetch in flight, then pulse reset for one edge
        Redirect = 1'b1; Redirect_Addr = 32'h100; Instr_Ready = 1'b0;
        step();
        Redirect = 1'b0;
        step(); step(); step(); step();
        chk("e_pre_count", {29'h0, Count}, 32'h3);
        chk("e_pre_req",   {31'h0, Mem_Req}, 32'h0);
        chk("e_pre_pc",    Instr_PC, 32'h100);
        Reset = 1'b0; #1;
        chk("e_rst_req",   {31'h0, Mem_Req}, 32'h0);
        chk("e_rst_valid", {31'h0, Instr_Valid}, 32'h0);
        step();
        chk("e_rst_count", {29'h0, Count}, 32'h0);
        Reset = 1'b1; #1;
        chk("e_q0_req",  {31'h0, Mem_Req}, 32'h1);
        chk("e_q0_addr", Mem_Addr, 32'h0);
        step();
        chk("e_q1_count", {29'h0, Count}, 32'h0);
        chk("e_q1_valid", {31'h0, Instr_Valid}, 32'h0);
        step();
        chk("e_q2_count", {29'h0, Count}, 32'h1);
        chk("e_q2_pc",    Instr_PC, 32'h0);

        // Fill to 4, then Redirect and pop in the same cycle
        step(); step(); step();
        chk("f_full_count", {29'h0, Count}, 32'h4);
        Instr_Ready = 1'b1; Redirect = 1'b1; Redirect_Addr = 32'h200; #1;
        chk("f_redir_req", {31'h0, Mem_Req}, 32'h0);
        step();
        Redirect = 1'b0; #1;
        chk("f_r1_count", {29'h0, Count}, 32'h0);
        chk("f_r1_valid", {31'h0, Instr_Valid}, 32'h0);
        chk("f_r1_addr",  Mem_Addr, 32'h200);
        step(); step();
        chk("f_r3_pc",    Instr_PC, 32'h200);
        chk("f_r3_instr", Instr, 32'h1200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
